// File: rtl/motoro3_line_pkg.sv
// Shared types and widths for the per-phase line PWM sequencer.
// Holds the FSM state enum and the step/length/speed field widths.
package motoro3_line_pkg;

  localparam int unsigned LC_STEP_W = 4;
  localparam int unsigned LC_LEN_W  = 16;
  localparam int unsigned LC_SPD_W  = 25;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } lc_state_e;

endpackage

// File: rtl/motoro3_pwm_period_cnt.sv
// Wrapping PWM period counter with synchronous clear, plus the high-window compare.
// MOTORO3_LINE_DEADTIME_EN blanks the first DEAD_CYC counts of every period.
module motoro3_pwm_period_cnt
  import motoro3_line_pkg::*;
#(
  parameter int unsigned DEAD_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [LC_LEN_W-1:0] period,
  input  logic [LC_LEN_W-1:0] high_len,
  output logic                pwm_raw
);

`ifdef MOTORO3_LINE_DEADTIME_EN
  localparam bit DeadEn = 1'b1;
`else
  localparam bit DeadEn = 1'b0;
`endif

  logic [LC_LEN_W-1:0] cnt_q, cnt_d;

  // period is clamped to >= 1 upstream, so period - 1 never underflows
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q >= period - LC_LEN_W'(1)) ? '0 : cnt_q + LC_LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pwm_raw = (cnt_q < high_len) && !(DeadEn && (cnt_q < LC_LEN_W'(DEAD_CYC)));

endmodule

// File: rtl/motoro3_line_pwm_gen.sv
// Per-phase step sequencer and PWM line generator (IDLE -> LOAD -> RUN).
// Optional dead time via MOTORO3_LINE_DEADTIME_EN (handled in the period counter).
module motoro3_line_pwm_gen
  import motoro3_line_pkg::*;
#(
  parameter int unsigned STEP_LAST = 15,
  parameter int unsigned DEAD_CYC  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m3r_enable,
  input  logic [LC_SPD_W-1:0]  m3r_stepCNT_speedSET,
  input  logic [LC_LEN_W-1:0]  plLen,
  input  logic [LC_LEN_W-1:0]  slLen,
  output logic [LC_STEP_W-1:0] lcStep,
  output logic                 lcPwmOut,
  output logic                 lcStepTick,
  output logic                 lcBusy
);

  lc_state_e            state_q, state_d;
  logic [LC_LEN_W-1:0]  pl_q, sl_q, pl_clamp, sl_clamp;
  logic [LC_SPD_W-1:0]  spd_q, spd_clamp, step_cnt_q, step_cnt_d;
  logic [LC_STEP_W-1:0] step_q, step_d;
  logic                 pwm_q, pwm_d, tick_q, tick_d;
  logic                 step_done, pwm_raw;

  always_comb begin
    pl_clamp  = (plLen == '0) ? LC_LEN_W'(1) : plLen;
    sl_clamp  = (slLen > pl_clamp) ? pl_clamp : slLen;
    spd_clamp = (m3r_stepCNT_speedSET == '0) ? LC_SPD_W'(1) : m3r_stepCNT_speedSET;
  end

  assign step_done = (state_q == StRun) && (step_cnt_q == spd_q - LC_SPD_W'(1));

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    step_cnt_d = step_cnt_q;
    tick_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (m3r_enable) state_d = StLoad;
      end
      StLoad: begin
        state_d    = StRun;
        step_cnt_d = '0;
      end
      StRun: begin
        if (step_done) begin
          state_d = StLoad;
          step_d  = (step_q == LC_STEP_W'(STEP_LAST)) ? '0 : step_q + LC_STEP_W'(1);
          tick_d  = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q + LC_SPD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Disable beats everything, including the terminal RUN cycle's advance
    if (!m3r_enable) begin
      state_d = StIdle;
      step_d  = step_q;
      tick_d  = 1'b0;
    end
  end

  // Only drive high when RUN continues, which keeps the line low during LOAD
  assign pwm_d = (state_q == StRun) && (state_d == StRun) && pwm_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      step_q     <= '0;
      step_cnt_q <= '0;
      pwm_q      <= 1'b0;
      tick_q     <= 1'b0;
      pl_q       <= '0;
      sl_q       <= '0;
      spd_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      step_cnt_q <= step_cnt_d;
      pwm_q      <= pwm_d;
      tick_q     <= tick_d;
      if (state_q == StLoad) begin
        pl_q  <= pl_clamp;
        sl_q  <= sl_clamp;
        spd_q <= spd_clamp;
      end
    end
  end

  motoro3_pwm_period_cnt #(
    .DEAD_CYC (DEAD_CYC)
  ) u_period_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == StLoad),
    .en       (state_q == StRun),
    .period   (pl_q),
    .high_len (sl_q),
    .pwm_raw  (pwm_raw)
  );

  assign lcStep     = step_q;
  assign lcPwmOut   = pwm_q;
  assign lcStepTick = tick_q;
  assign lcBusy     = (state_q != StIdle);

endmodule
